// File: rtl/spi_reg_ctrl.sv
// ============================================================================
// spi_reg_ctrl : register command sequencer in front of an SPI byte engine
// Optional macro: SPI_REG_CTRL_TIMEOUT_EN (per-byte receive timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_reg_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic       i_cmd_write,
  input  logic [6:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_cmd_ready,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  input  logic       i_rsp_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_ready,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_CMD  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4,
    RESP      = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             expired;

  // Terminal count is TIMEOUT_CYCLES-1 so the wait lasts exactly TIMEOUT_CYCLES cycles.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    tx_byte_d   = tx_byte_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          write_d   = i_cmd_write;
          wdata_d   = i_cmd_wdata;
          tx_byte_d = {~i_cmd_write, i_cmd_addr};
          state_d   = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (i_tx_ready) begin
          state_d = WAIT_CMD;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_CMD: begin
        if (i_rx_valid) begin
          tx_byte_d = write_q ? wdata_q : 8'h00;
          state_d   = SEND_DATA;
        end
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        else if (expired) begin
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SEND_DATA: begin
        if (i_tx_ready) begin
          state_d = WAIT_DATA;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_DATA: begin
        if (i_rx_valid) begin
          rsp_rdata_d = i_rx_byte;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        else if (expired) begin
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      tx_byte_q   <= 8'h00;
      rsp_rdata_q <= 8'h00;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      tx_byte_q   <= tx_byte_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_tx_valid  = (state_q == SEND_CMD) || (state_q == SEND_DATA);
  assign o_tx_byte   = tx_byte_q;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_rdata_q;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
  assign o_rsp_err   = rsp_err_q;
`else
  assign o_rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// ============================================================================
// tb_spi_reg_ctrl : directed vector bench for spi_reg_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cmd_valid = 1'b0, i_cmd_write = 1'b0;
  logic [6:0] i_cmd_addr = 7'h00;
  logic [7:0] i_cmd_wdata = 8'h00;
  logic       o_cmd_ready, o_rsp_valid, o_rsp_err, o_tx_valid;
  logic [7:0] o_rsp_rdata, o_tx_byte;
  logic       i_rsp_ready = 1'b0, i_tx_ready = 1'b0, i_rx_valid = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;

  spi_reg_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .o_cmd_ready(o_cmd_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .i_rsp_ready(i_rsp_ready),
    .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte), .i_tx_ready(i_tx_ready),
    .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rx0;
    logic [7:0] rx1;
    logic [7:0] exp_hdr;
    logic [7:0] exp_data;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Handshake / timing observers
  int cyc = 0, hs_cnt = 0, rsp_cyc_cnt = 0, acc_n = 0, last_rsp_cyc = -100;
  int acc_gap[64];

  always @(posedge clk) begin
    if (o_tx_valid && i_tx_ready) hs_cnt++;
    if (o_rsp_valid) rsp_cyc_cnt++;
    if (o_cmd_ready && i_cmd_valid && !rst) begin
      if (acc_n < 64) acc_gap[acc_n] = cyc - last_rsp_cyc;
      acc_n++;
    end
    if (o_rsp_valid && i_rsp_ready) last_rsp_cyc = cyc;
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
    check("cmd_ready_idle", o_cmd_ready, 1);
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = wdata;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("tx_valid_after_accept", o_tx_valid, 1);
    check("cmd_ready_busy", o_cmd_ready, 0);
  endtask

  task automatic tx_hs(input logic [7:0] exp_byte, input int stall);
    int k = 0;
    while (!o_tx_valid && k < 50) begin @(negedge clk); k++; end
    check("tx_valid_wait", o_tx_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check("tx_byte_stall", o_tx_byte, exp_byte);
      check("tx_valid_stall", o_tx_valid, 1);
      check("cmd_ready_stall", o_cmd_ready, 0);
      i_rx_valid = (s == 3); i_rx_byte = 8'hEE;
      @(negedge clk);
      i_rx_valid = 1'b0;
    end
    check("tx_byte", o_tx_byte, exp_byte);
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    check("tx_valid_drop", o_tx_valid, 0);
  endtask

  task automatic rx_pulse(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    i_rx_valid = 1'b1; i_rx_byte = b;
    @(negedge clk);
    i_rx_valid = 1'b0; i_rx_byte = 8'h5D;
  endtask

  task automatic rsp(input logic [7:0] exp_rdata, input logic exp_err, input int stall);
    int k = 0;
    while (!o_rsp_valid && k < 200) begin @(negedge clk); k++; end
    check("rsp_valid_wait", o_rsp_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check("rsp_valid_stall", o_rsp_valid, 1);
      check("rsp_rdata_stall", o_rsp_rdata, exp_rdata);
      check("cmd_ready_resp", o_cmd_ready, 0);
      @(negedge clk);
    end
    check("rsp_rdata", o_rsp_rdata, exp_rdata);
    check("rsp_err", o_rsp_err, exp_err);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("rsp_valid_drop", o_rsp_valid, 0);
    check("cmd_ready_after_rsp", o_cmd_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int hs0 = hs_cnt;
    issue_cmd(v.wr, v.addr, v.wdata);
    tx_hs(v.exp_hdr, 0);
    rx_pulse(v.rx0, 2);
    tx_hs(v.exp_data, 0);
    rx_pulse(v.rx1, 3);
    rsp(v.exp_rdata, 1'b0, 0);
    check("tx_handshakes", hs_cnt - hs0, 2);
  endtask

  initial begin
    int hs0, rsp0, acc0, k;

    vecs[0] = '{1'b1, 7'h12, 8'hA5, 8'h00, 8'h3C, 8'h12, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 7'h05, 8'h00, 8'hFF, 8'h7E, 8'h85, 8'h00, 8'h7E};
    vecs[2] = '{1'b1, 7'h7F, 8'h5A, 8'h11, 8'hC3, 8'h7F, 8'h5A, 8'hC3};
    vecs[3] = '{1'b0, 7'h00, 8'hFF, 8'hAA, 8'h01, 8'h80, 8'h00, 8'h01};
    vecs[4] = '{1'b1, 7'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{1'b0, 7'h7F, 8'h33, 8'h00, 8'h96, 8'hFF, 8'h00, 8'h96};

    // Reset state
    #2;
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_byte", o_tx_byte, 8'h00);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_rdata", o_rsp_rdata, 8'h00);
    check("rst_rsp_err", o_rsp_err, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: header stalled 10 cycles (stray rx inside), response stalled 5
    hs0 = hs_cnt;
    issue_cmd(1'b0, 7'h05, 8'h00);
    tx_hs(8'h85, 10);
    rx_pulse(8'hFF, 1);
    tx_hs(8'h00, 0);
    rx_pulse(8'h7E, 0);
    rsp(8'h7E, 1'b0, 5);
    check("bp_tx_handshakes", hs_cnt - hs0, 2);

    // tx_ready coinciding with rx_valid in WAIT_CMD: only the WAIT transition happens
    hs0 = hs_cnt;
    issue_cmd(1'b1, 7'h20, 8'h99);
    tx_hs(8'h20, 0);
    i_tx_ready = 1'b1; i_rx_valid = 1'b1; i_rx_byte = 8'h00;
    @(negedge clk);
    i_tx_ready = 1'b0; i_rx_valid = 1'b0;
    check("coinc_tx_valid", o_tx_valid, 1);
    check("coinc_tx_byte", o_tx_byte, 8'h99);
    check("coinc_handshakes", hs_cnt - hs0, 1);
    tx_hs(8'h99, 0);
    rx_pulse(8'h4D, 1);
    rsp(8'h4D, 1'b0, 0);
    check("coinc_total_hs", hs_cnt - hs0, 2);

    // Reset during WAIT_DATA of a read
    rsp0 = rsp_cyc_cnt;
    issue_cmd(1'b0, 7'h05, 8'h00);
    tx_hs(8'h85, 0);
    rx_pulse(8'hFF, 1);
    tx_hs(8'h00, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", o_cmd_ready, 1);
    check("mid_rst_tx_valid", o_tx_valid, 0);
    check("mid_rst_tx_byte", o_tx_byte, 8'h00);
    check("mid_rst_rsp_valid", o_rsp_valid, 0);
    check("mid_rst_rsp_rdata", o_rsp_rdata, 8'h00);
    check("mid_rst_rsp_err", o_rsp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_pulse(8'h77, 0);
    check("stray_rx_cmd_ready", o_cmd_ready, 1);
    check("stray_rx_tx_valid", o_tx_valid, 0);
    check("stray_rx_rsp_valid", o_rsp_valid, 0);
    check("rst_no_response", rsp_cyc_cnt - rsp0, 0);
    run_vec(vecs[1]);

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    // Timeout after header: response 16 cycles after entering WAIT_CMD
    issue_cmd(1'b0, 7'h05, 8'h00);
    tx_hs(8'h85, 0);
    k = 0;
    while (!o_rsp_valid && k < 100) begin @(negedge clk); k++; end
    check("timeout_latency", k, 16);
    rsp(8'h00, 1'b1, 0);
    // rx_valid on the expiry cycle wins
    issue_cmd(1'b0, 7'h01, 8'h00);
    tx_hs(8'h81, 0);
    repeat (15) @(negedge clk);
    rx_pulse(8'h00, 0);
    check("expiry_rx_wins", o_rsp_valid, 0);
    tx_hs(8'h00, 0);
    rx_pulse(8'h42, 1);
    rsp(8'h42, 1'b0, 0);
    run_vec(vecs[1]);
`else
    // Without the timeout the WAIT state is held indefinitely
    issue_cmd(1'b0, 7'h05, 8'h00);
    tx_hs(8'h85, 0);
    repeat (40) @(negedge clk);
    check("no_timeout_rsp_valid", o_rsp_valid, 0);
    check("no_timeout_tx_valid", o_tx_valid, 0);
    rx_pulse(8'hFF, 0);
    tx_hs(8'h00, 0);
    rx_pulse(8'h7E, 0);
    rsp(8'h7E, 1'b0, 0);
`endif

    // Back-to-back: three commands presented continuously
    acc0 = acc_n;
    hs0  = hs_cnt;
    fork
      begin
        for (int c = 0; c < 3; c++) begin
          int w = 0;
          i_cmd_valid = 1'b1; i_cmd_write = vecs[c].wr;
          i_cmd_addr = vecs[c].addr; i_cmd_wdata = vecs[c].wdata;
          while (!o_cmd_ready && w < 200) begin @(negedge clk); w++; end
          @(negedge clk);
        end
        i_cmd_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 3; c++) begin
          tx_hs(vecs[c].exp_hdr, 0);
          rx_pulse(vecs[c].rx0, 1);
          tx_hs(vecs[c].exp_data, 0);
          rx_pulse(vecs[c].rx1, 1);
          rsp(vecs[c].exp_rdata, 1'b0, 0);
        end
      end
    join
    check("b2b_accepts", acc_n - acc0, 3);
    check("b2b_gap1", acc_gap[acc0 + 1], 1);
    check("b2b_gap2", acc_gap[acc0 + 2], 1);
    check("b2b_handshakes", hs_cnt - hs0, 6);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
